// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake status; ACCESS marks the cycle a word completes
//   cc_state_t  : coherence controller FSM states
//   block_base  : two-word block base address (bits [2:0] cleared)
//   word_align  : word address (bits [1:0] cleared)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ARB      = 4'd1,
    SNOOP    = 4'd2,
    C2C_0    = 4'd3,
    C2C_1    = 4'd4,
    RAM_0    = 4'd5,
    RAM_1    = 4'd6,
    WB       = 4'd7,
    INV_DONE = 4'd8
  } cc_state_t;

  function automatic word_t block_base(input word_t a);
    return {a[31:3], 3'b000};
  endfunction

  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/coherence_control.sv
// Two-cache snoopy coherence controller sitting between the caches and a
// single-ported RAM. One transaction is serviced at a time; the requester (r)
// is chosen round-robin, the other cache (s) is snooped.
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   dREN/dWEN/cctrans[1:0]     per-cache read / write / exclusivity requests
//   daddr/dstore[1:0]          per-cache address and write/supply data
//   ccwrite[1:0]               snooped cache holds the block dirty
//   dwait[1:0], dload[1:0]     per-cache completion strobe (active low), read data
//   ccwait/ccinv[1:0]          snoop mode / invalidate to each cache
//   ccsnoopaddr[1:0]           address being snooped
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate   RAM side
//   state_dbg                  current FSM state, for observation only
//
// Handshake: a cache holds its request (and address/data) steady; the word
// completes in the single cycle where its dwait bit is low. dwait is low only
// while ramstate==ACCESS in a RAM-backed state, or in INV_DONE. Outputs are
// combinational from the registered state and current inputs so that the
// completion cycle lines up exactly with ramstate==ACCESS.
module coherence_control
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  word_t [1:0]      daddr,
  input  word_t [1:0]      dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output word_t [1:0]      dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output word_t [1:0]      ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output cc_state_t        state_dbg
);

  cc_state_t state_q, state_d;
  logic      rr_q, rr_d;          // round-robin pointer: cache favoured on collision
  logic      req_q, req_d;        // latched requester id (r)
  logic      snooped_q, snooped_d; // first SNOOP cycle done; ccwrite valid next

  logic       r;
  logic       s;
  logic [1:0] any_req;
  logic       ram_done;
  word_t      snoop_base;

  assign r          = req_q;
  assign s          = ~req_q;
  assign any_req    = dREN | dWEN | cctrans;
  // BUSY, FREE and ERROR all stall; only ACCESS completes a word.
  assign ram_done   = (ramstate == ACCESS);
  assign snoop_base = block_base(daddr[r]);
  assign state_dbg  = state_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    req_d       = req_q;
    snooped_d   = 1'b0;
    dwait       = 2'b11;
    dload       = {ramload, ramload};
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (|any_req) begin
          // On a collision the pointer decides; otherwise the lone requester wins.
          req_d   = (&any_req) ? rr_q : any_req[1];
          rr_d    = ~rr_q;
          state_d = ARB;
        end
      end

      ARB: begin
        if (dWEN[r])                    state_d = WB;
        else if (dREN[r] || cctrans[r]) state_d = SNOOP;
        else                            state_d = IDLE;
      end

      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = snoop_base;
        ccinv[s]       = cctrans[r];
        // Give the snooped cache one cycle to look up before trusting ccwrite.
        if (!snooped_q) begin
          snooped_d = 1'b1;
        end else if (cctrans[r] && !dREN[r]) begin
          state_d = INV_DONE;
        end else if (ccwrite[s]) begin
          state_d = C2C_0;
        end else begin
          state_d = RAM_0;
        end
      end

      INV_DONE: begin
        dwait[r] = 1'b0;
        state_d  = IDLE;
      end

      C2C_0, C2C_1: begin
        // Dirty block forwarded to r and written back to RAM in the same beat.
        ccwait[s]      = 1'b1;
        ccinv[s]       = cctrans[r];
        ccsnoopaddr[s] = snoop_base;
        dload[r]       = dstore[s];
        ramWEN         = 1'b1;
        ramaddr        = (state_q == C2C_1) ? (snoop_base | 32'd4) : snoop_base;
        ramstore       = dstore[s];
        if (ram_done) begin
          dwait   = 2'b00;
          state_d = (state_q == C2C_0) ? C2C_1 : IDLE;
        end
      end

      RAM_0, RAM_1: begin
        ramREN  = 1'b1;
        ramaddr = word_align(daddr[r]);
        if (ram_done) begin
          dwait[r] = 1'b0;
          state_d  = (state_q == RAM_0) ? RAM_1 : IDLE;
        end
      end

      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = word_align(daddr[r]);
        ramstore = dstore[r];
        if (ram_done) begin
          dwait[r] = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      req_q     <= 1'b0;
      snooped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      req_q     <= req_d;
      snooped_q <= snooped_d;
    end
  end

endmodule

// File: tb/tb_coherence_control.sv
// Directed bench for coherence_control: read miss, cache-to-cache transfer,
// invalidate-only, write collisions with round-robin, RAM stall, and reset
// in the middle of a cache-to-cache transfer. RAM writes are checked against
// an expected queue of {address, data} pairs.
module tb_coherence_control;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [1:0]  dREN, dWEN, cctrans, ccwrite;
  word_t [1:0] daddr, dstore;
  logic [1:0]  dwait, ccwait, ccinv;
  word_t [1:0] dload, ccsnoopaddr;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  cc_state_t   state_dbg;

  coherence_control dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];   // expected RAM writes, {addr, data}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every completed RAM write must match the head of the expected queue.
  always @(negedge CLK) begin
    if (ramWEN && ramstate == ACCESS) begin
      logic [63:0] exp_wr;
      exp_wr = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("ram_wr", {ramaddr, ramstore}, exp_wr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN     = '0;
    dWEN     = '0;
    cctrans  = '0;
    ccwrite  = '0;
    ramstate = FREE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    daddr   = '0;
    dstore  = '0;
    ramload = '0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state",    state_dbg, IDLE);
    check("rst_dwait",    dwait, 2'b11);
    check("rst_ccwait",   {ccwait, ccinv}, 4'b0000);
    check("rst_snoopadr", ccsnoopaddr, 64'h0);
    check("rst_ramstrb",  {ramREN, ramWEN}, 2'b00);
    check("rst_ramaddr",  {ramaddr, ramstore}, 64'h0);
    RST = 1'b0;
    step();

    // Read miss, no dirty copy in cache1
    dREN = 2'b01; daddr[0] = 32'h104;
    #1 check("rd_idle_dwait", dwait, 2'b11);
    step(); check("rd_arb", state_dbg, ARB);
    step();
    check("rd_snoop",      state_dbg, SNOOP);
    check("rd_ccwait",     ccwait, 2'b10);
    check("rd_snoopaddr",  ccsnoopaddr[1], 32'h100);
    check("rd_ccinv",      ccinv, 2'b00);
    check("rd_snoop_ram",  {ramREN, ramWEN}, 2'b00);
    step(); check("rd_snoop_wait", state_dbg, SNOOP);
    step(); check("rd_ram0", state_dbg, RAM_0);
    ramload = 32'h1111_0000; ramstate = BUSY;
    #1;
    check("rd_busy_dwait", dwait, 2'b11);
    check("rd0_ren",       {ramREN, ramWEN}, 2'b10);
    check("rd0_addr",      ramaddr, 32'h104);
    step(); ramstate = ACCESS;
    #1;
    check("rd0_dwait", dwait, 2'b10);
    check("rd0_dload", dload[0], 32'h1111_0000);
    step(); check("rd_ram1", state_dbg, RAM_1);
    daddr[0] = 32'h108; ramload = 32'h2222_0000;
    #1;
    check("rd1_addr",  ramaddr, 32'h108);
    check("rd1_dwait", dwait, 2'b10);
    check("rd1_dload", dload[0], 32'h2222_0000);
    step(); clear_inputs();
    check("rd_done", state_dbg, IDLE);
    #1 check("rd_done_dwait", dwait, 2'b11);
    step();

    // Read-exclusive with dirty copy in cache1: cache-to-cache transfer
    dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h200;
    ccwrite = 2'b10; dstore[1] = 32'h0000_AAAA;
    step(); check("c2c_arb", state_dbg, ARB);
    step();
    check("c2c_snoop_inv", ccinv, 2'b10);
    check("c2c_snoopaddr", ccsnoopaddr[1], 32'h200);
    step(); check("c2c_snoop_inv2", ccinv, 2'b10);
    step(); check("c2c_0", state_dbg, C2C_0);
    exp_q.push_back({32'h200, 32'h0000_AAAA});
    ramstate = ACCESS;
    #1;
    check("c2c0_strb",  {ramREN, ramWEN}, 2'b01);
    check("c2c0_addr",  ramaddr, 32'h200);
    check("c2c0_store", ramstore, 32'h0000_AAAA);
    check("c2c0_dload", dload[0], 32'h0000_AAAA);
    check("c2c0_dwait", dwait, 2'b00);
    check("c2c0_inv",   {ccwait, ccinv}, 4'b1010);
    step(); check("c2c_1", state_dbg, C2C_1);
    dstore[1] = 32'h0000_BBBB;
    exp_q.push_back({32'h204, 32'h0000_BBBB});
    #1;
    check("c2c1_addr",  ramaddr, 32'h204);
    check("c2c1_dload", dload[0], 32'h0000_BBBB);
    check("c2c1_dwait", dwait, 2'b00);
    check("c2c1_inv",   ccinv, 2'b10);
    step(); clear_inputs();
    check("c2c_done", state_dbg, IDLE);
    #1 check("c2c_done_cc", {ccwait, ccinv}, 4'b0000);
    step();

    // Invalidate-only from cache1
    cctrans = 2'b10; daddr[1] = 32'h40;
    step(); step();
    check("inv_snoop",     {ccwait, ccinv}, 4'b0101);
    check("inv_snoopaddr", ccsnoopaddr[0], 32'h40);
    check("inv_snoop_ram", {ramREN, ramWEN}, 2'b00);
    check("inv_snoop_dw",  dwait, 2'b11);
    step(); check("inv_snoop_ram2", {ramREN, ramWEN}, 2'b00);
    step();
    check("inv_done",    state_dbg, INV_DONE);
    check("inv_dwait",   dwait, 2'b01);
    check("inv_done_cc", {ccwait, ccinv}, 4'b0000);
    check("inv_ram",     {ramREN, ramWEN}, 2'b00);
    clear_inputs();
    step();
    check("inv_idle",  state_dbg, IDLE);
    check("inv_dwait1", dwait, 2'b11);

    // Write collision after reset: cache0 first, then cache1
    RST = 1'b1; step(); RST = 1'b0;
    dWEN = 2'b11;
    daddr[0] = 32'h300; dstore[0] = 32'h3;
    daddr[1] = 32'h400; dstore[1] = 32'h4;
    step(); check("col_arb", state_dbg, ARB);
    step();
    check("col1_wb",   state_dbg, WB);
    check("col1_addr", ramaddr, 32'h300);
    check("col1_wait", dwait, 2'b11);
    exp_q.push_back({32'h300, 32'h3});
    ramstate = ACCESS;
    #1 check("col1_dwait", dwait, 2'b10);
    step();
    // cache0 issues another write while cache1 is still waiting
    daddr[0] = 32'h304; dstore[0] = 32'h5; ramstate = FREE;
    step(); step();
    check("col2_addr", ramaddr, 32'h400);
    exp_q.push_back({32'h400, 32'h4});
    ramstate = ACCESS;
    #1 check("col2_dwait", dwait, 2'b01);
    step(); dWEN = 2'b01; ramstate = FREE;

    // Writeback stalled by RAM
    step(); step();
    check("stall_wb", state_dbg, WB);
    ramstate = BUSY;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_dwait", dwait, 2'b11);
      check("stall_wen",   {ramREN, ramWEN}, 2'b01);
      check("stall_addr",  {ramaddr, ramstore}, {32'h304, 32'h5});
      step();
    end
    ramstate = ERROR;
    #1 check("stall_err", dwait, 2'b11);
    step();
    exp_q.push_back({32'h304, 32'h5});
    ramstate = ACCESS;
    #1 check("stall_done", dwait, 2'b10);
    step(); clear_inputs();
    check("stall_idle", state_dbg, IDLE);
    step();

    // Reset during C2C_1
    dREN = 2'b10; daddr[1] = 32'h500; ccwrite = 2'b01; dstore[0] = 32'hC0;
    step(); step(); step(); step();
    check("rc_c2c0", state_dbg, C2C_0);
    exp_q.push_back({32'h500, 32'hC0});
    ramstate = ACCESS;
    #1 check("rc_dload", dload[1], 32'hC0);
    step();
    check("rc_c2c1", state_dbg, C2C_1);
    ramstate = BUSY; dstore[0] = 32'hC1;
    #1 check("rc_addr", ramaddr, 32'h504);
    RST = 1'b1;
    #1;
    check("rc_state",   state_dbg, IDLE);
    check("rc_strb",    {ramREN, ramWEN}, 2'b00);
    check("rc_ramaddr", {ramaddr, ramstore}, 64'h0);
    check("rc_dwait",   dwait, 2'b11);
    check("rc_cc",      {ccwait, ccinv}, 4'b0000);
    check("rc_snoop",   ccsnoopaddr, 64'h0);
    clear_inputs();
    step(); RST = 1'b0;
    step(); step();
    check("rc_after", {ramREN, ramWEN}, 2'b00);
    check("rc_after_st", state_dbg, IDLE);

    // ---------------- report ----------------
    check("wr_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/coherence_control.md
COHERENCE_CONTROL -- requirements
Module: coherence_control

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: none; the cache count SHALL be fixed at 2, and all per-cache ports SHALL be [1:0] arrays indexed by cache id.
REQ-003 CLK  in  1  system clock, rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 dREN  in  2  cache requests a memory read (block miss fill).
REQ-006 dWEN  in  2  cache requests a memory write (writeback, flush, or snoop data supply).
REQ-007 daddr  in  2x32  cache request address; bits [1:0] are ignored.
REQ-008 dstore  in  2x32  cache write data, or snoop supply data.
REQ-009 cctrans  in  2  cache requests exclusivity; alone means invalidate-only, with dREN means read-exclusive.
REQ-010 ccwrite  in  2  snooped cache holds the block dirty and will supply it.
REQ-011 dwait  out  2  low for exactly the cycle a request word completes.
REQ-012 dload  out  2x32  read data returned to a cache.
REQ-013 ccwait  out  2  puts the cache into snoop mode.
REQ-014 ccinv  out  2  snooped cache invalidates its matching block.
REQ-015 ccsnoopaddr  out  2x32  address being snooped.
REQ-016 ramREN  out  1  RAM read strobe.
REQ-017 ramWEN  out  1  RAM write strobe.
REQ-018 ramaddr  out  32  RAM word address.
REQ-019 ramstore  out  32  RAM write data.
REQ-020 ramload  in  32  RAM read data.
REQ-021 ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR; ACCESS marks the completion cycle.

Function
REQ-022 States SHALL be IDLE, ARB, SNOOP, C2C_0, C2C_1, RAM_0, RAM_1, WB, INV_DONE; r = requester, s = the other cache (!r).
REQ-023 IDLE: when any dREN|dWEN|cctrans is asserted, the block SHALL latch r by round-robin and go to ARB; the priority pointer SHALL flip after each grant.
REQ-024 Simultaneous requests from both caches: the cache not favoured by the pointer SHALL wait, with dwait held high.
REQ-025 ARB routing: dWEN[r] -> WB; dREN[r] or cctrans[r] -> SNOOP.
REQ-026 WB: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]; on ACCESS, dwait[r]=0 and go to IDLE; there is no snoop on writeback.
REQ-027 SNOOP: ccwait[s]=1, ccsnoopaddr[s]=daddr[r] with bits [2:0] cleared, ccinv[s]=cctrans[r]; the block SHALL wait one cycle, then sample ccwrite[s].
REQ-028 From SNOOP: invalidate-only (cctrans without dREN) -> INV_DONE; ccwrite[s]=1 -> C2C_0; otherwise -> RAM_0.
REQ-029 INV_DONE: dwait[r]=0 for one cycle, ccwait[s] and ccinv[s] deasserted, then IDLE.
REQ-030 C2C_n (n=0,1): ccwait[s] and ccinv[s] held; dload[r]=dstore[s]; ramWEN=1 with ramaddr=block base+4n and ramstore=dstore[s].
REQ-031 C2C_n completion: on ACCESS, dwait[r]=0 and dwait[s]=0 in the same cycle; C2C_0 -> C2C_1, C2C_1 -> IDLE.
REQ-032 RAM_n: ramREN=1, ramaddr=daddr[r], dload[r]=ramload; on ACCESS, dwait[r]=0; RAM_0 -> RAM_1 -> IDLE.
REQ-033 ramstate BUSY/FREE SHALL stall any state with all dwait held high; ERROR SHALL be treated as BUSY.
REQ-034 ramREN and ramWEN SHALL never be asserted together; outside WB/C2C/RAM states both SHALL be 0.
REQ-035 dwait SHALL default to 1 for both caches; dload SHALL default to ramload.
REQ-036 A request from s that arrives during r's transaction SHALL be ignored until IDLE.

Reset
REQ-037 While RST=1, the block SHALL be in state IDLE with the pointer favouring cache 0, ccwait=ccinv=0, dwait=2'b11, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0; reset mid-transaction SHALL abort it with no RAM write completed afterward.

Structure
REQ-038 ramstate_t and word_t SHALL come from cpu_types_pkg; the cc_state_t enum SHALL be added to cpu_types_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; next-state/output logic SHALL be one always_comb, with registers held in always_ff.

Verification
REQ-040 Cache0 dREN with daddr=0x104, cache1 ccwrite=0 -> SNOOP with ccsnoopaddr[1]=0x100, then RAM reads 0x104 and 0x108, with dwait[0] low twice.
REQ-041 Cache0 dREN+cctrans with daddr=0x200, cache1 ccwrite=1, dstore 0xAAAA then 0xBBBB -> dload[0] returns 0xAAAA then 0xBBBB, RAM is written at 0x200/0x204, and ccinv[1]=1 throughout.
REQ-042 Cache1 cctrans only with daddr=0x40 -> ccinv[0]=1, no ramREN/ramWEN asserted, dwait[1] low exactly one cycle.
REQ-043 Both caches assert dWEN in the same cycle after reset -> cache0 is served first; on the next collision cache1 is served first.
REQ-044 ramstate held BUSY for 5 cycles during WB -> dwait stays high for 5 cycles, and ramWEN/ramaddr stay stable.
REQ-045 RST asserted during C2C_1 -> all outputs take their reset values in the same cycle, and the state returns to IDLE.
